main_control_fsm: RTL
=====================

# main_control_fsm

Multi-cycle main control unit for the MIPS datapath. It decodes the opcode and funct fields held in the instruction register and sequences each instruction through fetch, decode, execute, memory and write-back states. Every cycle it drives the enables and selects consumed by the instruction fetch unit, register file, ALU and memory. It also handles exception entry: the EPC capture and the redirect to the exception vector.

## Interface
Parameters:
- OPCODE_WIDTH, 6, width of the Instr[31:26] opcode field
- FUNCT_WIDTH, 6, width of the Instr[5:0] funct field
- STATE_WIDTH, 4, width of the state register and the STATE debug output

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- OPCODE  in  6  Instr[31:26] from the instruction register
- FUNCT  in  6  Instr[5:0] from the instruction register
- ZERO  in  1  ALU zero flag, combinational, current cycle
- OVERFLOW  in  1  ALU signed-overflow flag, combinational, current cycle
- PC_LOAD  out  1  PC register enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALU register
- IR_EN  out  1  instruction register enable
- MEM_WE  out  1  data memory write enable
- MEM_TO_REG  out  1  write-back source: 0 = ALU register, 1 = memory data
- REG_DST  out  1  destination register: 0 = rt, 1 = rd
- REG_WE  out  1  register file write enable
- ALU_SRC_A  out  1  ALU A operand: 0 = PC, 1 = rs data
- ALU_SRC_B  out  2  ALU B operand: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALU_OP  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode from funct
- PC_SEL  out  3  next-PC mux: 0 = ALU_OUT, 1 = ALU_REG_OUT, 2 = jump concat, 3 = Reg1_Out, 4 = zero vector
- EPC_EN  out  1  EPC register enable
- EPC_SEL  out  1  EPC source: 0 = PC_OUT, 1 = rt data
- STATE  out  4  current state, for debug and coverage

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JR, MTC0, EXC.
- Output decode is Moore: outputs depend only on the current state. The single exception is PC_LOAD in BRANCH, which follows ZERO.
- Any output not listed for a state is 0.
- FETCH: IorD=0, IR_EN=1, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=00, PC_SEL=0, PC_LOAD=1. Result: PC <= PC+4. Next state DECODE.
- DECODE: ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=00, which precomputes the branch target into the ALU register. Next state by opcode:
  - 100011 (lw) and 101011 (sw) -> MEM_ADDR
  - 000000 with FUNCT 001000 (jr) -> JR; any other 000000 -> R_EXEC
  - 001000 (addi) -> I_EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 010000 -> MTC0
  - any other opcode -> EXC
- MEM_ADDR: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1. Next state MEM_WB.
- MEM_WB: REG_WE=1, MEM_TO_REG=1, REG_DST=0. Next state FETCH.
- MEM_WR: IorD=1, MEM_WE=1. Next state FETCH.
- R_EXEC: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=10. Next state EXC if OVERFLOW=1, otherwise R_WB.
- R_WB: REG_WE=1, REG_DST=1, MEM_TO_REG=0. Next state FETCH.
- I_EXEC: ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=00. Next state EXC if OVERFLOW=1, otherwise I_WB.
- I_WB: REG_WE=1, REG_DST=0, MEM_TO_REG=0. Next state FETCH.
- BRANCH: ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=01, PC_SEL=1, PC_LOAD=ZERO. Next state FETCH.
- JUMP: PC_SEL=2, PC_LOAD=1. Next state FETCH.
- JR: PC_SEL=3, PC_LOAD=1. Next state FETCH.
- MTC0: EPC_EN=1, EPC_SEL=1. Next state FETCH.
- EXC: EPC_EN=1, EPC_SEL=0, PC_SEL=4, PC_LOAD=1. EPC captures PC_OUT, which is the faulting instruction address + 4. PC is loaded with 0. Next state FETCH.
- Overflow never produces a register write, because the R_WB and I_WB states are skipped.

## Timing
- Reset: asynchronous. While RST=1, state = FETCH and every output, including STATE, is forced to 0.
- The first FETCH outputs appear in the first cycle after RST deasserts.
- Cycle counts, FETCH through the last state inclusive:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j, jr, mtc0: 3
  - illegal opcode: 3 (FETCH, DECODE, EXC)
  - overflow: 4 (FETCH, DECODE, R_EXEC or I_EXEC, EXC)
- State transitions occur on the rising edge of CLK. ZERO and OVERFLOW are sampled in the same cycle they are used.
- RST asserted mid-instruction aborts it immediately. No partial REG_WE, MEM_WE or EPC_EN pulse persists past the reset assertion.
- An unreachable or unknown state register value returns to FETCH on the next edge, with all outputs 0 in that cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - the state enumeration (4-bit encoding)
  - opcode and funct constants
  - ALU_OP, ALU_SRC_B and PC_SEL encodings
  - the exception vector constant, 0
- Sub-module mips_opcode_decoder: purely combinational, maps OPCODE and FUNCT to an instruction class (LS, RTYPE, JR, ADDI, BEQ, J, MTC0, ILLEGAL).
- The top level contains the state register, next-state logic and output decode.

## Test plan
- Reset, then lw (OPCODE 100011): STATE sequence FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH. IR_EN=1 only in cycle 1. REG_WE=1 and MEM_TO_REG=1 only in cycle 5.
- beq with ZERO=1, then beq with ZERO=0: PC_LOAD=1 with PC_SEL=1 in the BRANCH cycle for the first; PC_LOAD=0 in BRANCH for the second. Each instruction takes 3 cycles.
- add (000000, FUNCT 100000) with OVERFLOW=1 during R_EXEC -> next state EXC with EPC_EN=1, EPC_SEL=0, PC_SEL=4, PC_LOAD=1. No REG_WE pulse at any point.
- Illegal OPCODE 111111 -> FETCH, DECODE, EXC, FETCH, with the EPC capture and PC reset to 0 in EXC.
- jr (000000, FUNCT 001000) -> PC_SEL=3 and PC_LOAD=1 in cycle 3. mtc0 (010000) -> EPC_EN=1 and EPC_SEL=1 in cycle 3.
- RST asserted during MEM_WR -> all outputs 0 in the same cycle. After release, STATE=FETCH and MEM_WE is never seen high.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

  // Controller states; 4'd15 is never entered and falls back to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_MTC0     = 4'd13,
    S_EXC      = 4'd14
  } state_t;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [2:0] {
    CLS_LS,
    CLS_RTYPE,
    CLS_JR,
    CLS_ADDI,
    CLS_BEQ,
    CLS_J,
    CLS_MTC0,
    CLS_ILLEGAL
  } instr_class_t;

  // Opcode and funct values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // Next-PC mux select
  localparam logic [2:0] PC_SEL_ALU     = 3'd0;
  localparam logic [2:0] PC_SEL_ALU_REG = 3'd1;
  localparam logic [2:0] PC_SEL_JUMP    = 3'd2;
  localparam logic [2:0] PC_SEL_REG1    = 3'd3;
  localparam logic [2:0] PC_SEL_EXC_VEC = 3'd4;

  // Address the PC is loaded with on exception entry
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/mips_opcode_decoder.sv
// Maps opcode/funct to an instruction class plus a store flag.
// Latency: purely combinational.
// Backpressure: none.
module mips_opcode_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  output instr_class_t            instr_class,
  output logic                    is_store
);

  // Classify; anything unrecognised is illegal and traps
  always_comb begin
    instr_class = CLS_ILLEGAL;
    is_store    = 1'b0;
    case (opcode)
      OP_LW:    instr_class = CLS_LS;
      OP_SW: begin
        instr_class = CLS_LS;
        is_store    = 1'b1;
      end
      OP_RTYPE: instr_class = (funct == FN_JR) ? CLS_JR : CLS_RTYPE;
      OP_ADDI:  instr_class = CLS_ADDI;
      OP_BEQ:   instr_class = CLS_BEQ;
      OP_J:     instr_class = CLS_J;
      OP_COP0:  instr_class = CLS_MTC0;
      default:  instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/mem/wb and exception entry.
// Latency: 3-5 cycles per instruction; Moore outputs (PC_LOAD in BRANCH follows ZERO).
// Backpressure: none; advances every cycle, RST aborts and blanks all outputs at once.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [OPCODE_WIDTH-1:0] OPCODE,
  input  logic [FUNCT_WIDTH-1:0]  FUNCT,
  input  logic                    ZERO,
  input  logic                    OVERFLOW,
  output logic                    PC_LOAD,
  output logic                    IorD,
  output logic                    IR_EN,
  output logic                    MEM_WE,
  output logic                    MEM_TO_REG,
  output logic                    REG_DST,
  output logic                    REG_WE,
  output logic                    ALU_SRC_A,
  output logic [1:0]              ALU_SRC_B,
  output logic [1:0]              ALU_OP,
  output logic [2:0]              PC_SEL,
  output logic                    EPC_EN,
  output logic                    EPC_SEL,
  output logic [STATE_WIDTH-1:0]  STATE
);

  state_t       state;
  state_t       state_nxt;
  instr_class_t instr_class;
  logic         is_store;

  mips_opcode_decoder #(
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_decoder (
    .opcode     (OPCODE),
    .funct      (FUNCT),
    .instr_class(instr_class),
    .is_store   (is_store)
  );

  // State register; reset parks the machine in FETCH
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state sequencing; overflow diverts to EXC so no write-back happens
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (instr_class)
          CLS_LS:    state_nxt = S_MEM_ADDR;
          CLS_RTYPE: state_nxt = S_R_EXEC;
          CLS_JR:    state_nxt = S_JR;
          CLS_ADDI:  state_nxt = S_I_EXEC;
          CLS_BEQ:   state_nxt = S_BRANCH;
          CLS_J:     state_nxt = S_JUMP;
          CLS_MTC0:  state_nxt = S_MTC0;
          default:   state_nxt = S_EXC;
        endcase
      end
      S_MEM_ADDR: state_nxt = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_nxt = S_MEM_WB;
      S_R_EXEC:   state_nxt = OVERFLOW ? S_EXC : S_R_WB;
      S_I_EXEC:   state_nxt = OVERFLOW ? S_EXC : S_I_WB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Output decode per state; everything held low while RST is asserted
  always_comb begin
    PC_LOAD    = 1'b0;
    IorD       = 1'b0;
    IR_EN      = 1'b0;
    MEM_WE     = 1'b0;
    MEM_TO_REG = 1'b0;
    REG_DST    = 1'b0;
    REG_WE     = 1'b0;
    ALU_SRC_A  = 1'b0;
    ALU_SRC_B  = ALU_B_RT;
    ALU_OP     = ALU_OP_ADD;
    PC_SEL     = PC_SEL_ALU;
    EPC_EN     = 1'b0;
    EPC_SEL    = 1'b0;
    if (!RST) begin
      case (state)
        S_FETCH: begin
          IR_EN     = 1'b1;
          ALU_SRC_B = ALU_B_FOUR;
          PC_LOAD   = 1'b1;
        end
        S_DECODE:   ALU_SRC_B = ALU_B_IMM_SH2;
        S_MEM_ADDR: begin
          ALU_SRC_A = 1'b1;
          ALU_SRC_B = ALU_B_IMM;
        end
        S_MEM_RD:   IorD = 1'b1;
        S_MEM_WB: begin
          REG_WE     = 1'b1;
          MEM_TO_REG = 1'b1;
        end
        S_MEM_WR: begin
          IorD   = 1'b1;
          MEM_WE = 1'b1;
        end
        S_R_EXEC: begin
          ALU_SRC_A = 1'b1;
          ALU_OP    = ALU_OP_FUNCT;
        end
        S_R_WB: begin
          REG_WE  = 1'b1;
          REG_DST = 1'b1;
        end
        S_I_EXEC: begin
          ALU_SRC_A = 1'b1;
          ALU_SRC_B = ALU_B_IMM;
        end
        S_I_WB:     REG_WE = 1'b1;
        S_BRANCH: begin
          ALU_SRC_A = 1'b1;
          ALU_OP    = ALU_OP_SUB;
          PC_SEL    = PC_SEL_ALU_REG;
          PC_LOAD   = ZERO;
        end
        S_JUMP: begin
          PC_SEL  = PC_SEL_JUMP;
          PC_LOAD = 1'b1;
        end
        S_JR: begin
          PC_SEL  = PC_SEL_REG1;
          PC_LOAD = 1'b1;
        end
        S_MTC0: begin
          EPC_EN  = 1'b1;
          EPC_SEL = 1'b1;
        end
        S_EXC: begin
          EPC_EN  = 1'b1;
          PC_SEL  = PC_SEL_EXC_VEC;
          PC_LOAD = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Async reset drives state to FETCH (encoding 0), so STATE reads 0 in reset
  assign STATE = STATE_WIDTH'(state);

endmodule
